// File: rtl/cell_bus_arbiter.sv
// cell_bus_arbiter
//   Round-robin arbiter that shares one registered DATA_W-bit bus among N_REQ
//   requesters. One requester is granted at a time, and its data is captured onto
//   bus_out every cycle it keeps req high. A grant is force-released after
//   MAX_HOLD captured cycles, with a one-cycle timeout pulse. MAX_HOLD = 0 means
//   there is no limit. Every release is followed by one gnt=0 turnaround cycle.
//
// Ports
//   clk        in   rising-edge clock
//   r          in   asynchronous active-high reset
//   req        in   per-requester level request
//   data_in    in   packed requester data, requester i at [i*DATA_W +: DATA_W]
//   gnt        out  registered one-hot grant (or zero)
//   gnt_id     out  index of the current grant, or of the last grant when gnt=0
//   bus_out    out  registered data of the granted requester
//   bus_valid  out  bus_out was captured from an active grant
//   timeout    out  one-cycle pulse when a grant is force-released

module cell_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 15,
    localparam int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      r,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [IDX_W-1:0]          gnt_id,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic                      timeout
);

    // The hold counter must be able to reach MAX_HOLD. It needs at least one bit.
    localparam int unsigned HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0]  HOLD_LIM = HC_W'(MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic [HC_W-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]    last_q, last_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    int                  cand;
    logic                req_sel;
    logic [DATA_W-1:0]   data_sel;
    logic                at_limit;

    // Round-robin search: start one past the last winner and wrap around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = (int'(last_q) + k) % int'(N_REQ);
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign req_sel  = req[gnt_id_q];
    assign data_sel = data_in[int'(gnt_id_q) * int'(DATA_W) +: DATA_W];
    // hold_q counts captured cycles. Reaching MAX_HOLD means the final beat is on the bus.
    assign at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

    // State register and all datapath registers
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            bus_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            bus_q     <= bus_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRelease: state_d = win_found ? StGrant : StIdle;
            StGrant:           if (!req_sel || at_limit) state_d = StRelease;
            default:           state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        bus_d     = bus_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        unique case (state_q)
            StIdle, StRelease: begin
                valid_d = 1'b0;
                if (win_found) begin
                    gnt_d    = ONE_HOT0 << win_idx;
                    gnt_id_d = win_idx;
                    hold_d   = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            StGrant: begin
                if (!req_sel || at_limit) begin
                    // bus_out keeps its last value through the release.
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    last_d    = gnt_id_q;
                    timeout_d = req_sel;
                end else begin
                    bus_d   = data_sel;
                    valid_d = 1'b1;
                    if (MAX_HOLD != 0) hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cell_bus_arbiter.sv
// Testbench for cell_bus_arbiter. It runs two instances on shared stimulus:
// instance a has MAX_HOLD=15 and instance b has MAX_HOLD=0 (unlimited hold).
// A behavioural model pushes the expected outputs of both instances into a
// scoreboard queue for every clock edge. The entries are popped and compared
// once the edge has settled.

module tb_cell_bus_arbiter;

    logic        clk;
    logic        r;
    logic [3:0]  req;
    logic [31:0] data_in;

    logic [3:0]  gnt_a, gnt_b;
    logic [1:0]  gid_a, gid_b;
    logic [7:0]  bus_a, bus_b;
    logic        bv_a, bv_b;
    logic        to_a, to_b;

    cell_bus_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(15)) dut_a (
        .clk       (clk),
        .r         (r),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt_a),
        .gnt_id    (gid_a),
        .bus_out   (bus_a),
        .bus_valid (bv_a),
        .timeout   (to_a)
    );

    cell_bus_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(0)) dut_b (
        .clk       (clk),
        .r         (r),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt_b),
        .gnt_id    (gid_b),
        .bus_out   (bus_b),
        .bus_valid (bv_b),
        .timeout   (to_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         st;    // 0 idle, 1 grant, 2 release
        int         last;
        int         gid;
        int         hc;
        logic [3:0] gnt;
        logic [7:0] bus;
        logic       bv;
        logic       to;
    } mdl_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] gid;
        logic [7:0] bus;
        logic       bv;
        logic       to;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    pair_t sb[$];
    mdl_t  ma, mb;
    int    n_checks = 0;
    int    n_errors = 0;
    int    to_cnt_a, to_cnt_b, run_a, max_run_a, hold_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = 0; m.last = 3; m.gid = 0; m.hc = 0;
        m.gnt = '0; m.bus = '0; m.bv = 1'b0; m.to = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, logic [3:0] rq, logic [31:0] din, int mh);
        mdl_t n;
        bit   found;
        int   id;
        n     = s;
        n.to  = 1'b0;
        found = 1'b0;
        if (s.st == 1) begin
            id = s.gid;
            if (!rq[id[1:0]] || (mh != 0 && s.hc == mh)) begin
                n.to   = rq[id[1:0]];
                n.gnt  = '0;
                n.bv   = 1'b0;
                n.last = id;
                n.st   = 2;
            end else begin
                n.bus = din[id*8 +: 8];
                n.bv  = 1'b1;
                if (mh != 0) n.hc = s.hc + 1;
            end
        end else begin
            n.bv  = 1'b0;
            n.gnt = '0;
            n.st  = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (s.last + k) % 4;
                if (!found && rq[c[1:0]]) begin
                    found = 1'b1;
                    n.gnt = 4'b0001 << c;
                    n.gid = c;
                    n.hc  = 0;
                    n.st  = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.gnt = m.gnt;
        e.gid = m.gid[1:0];
        e.bus = m.bus;
        e.bv  = m.bv;
        e.to  = m.to;
        return e;
    endfunction

    task automatic push_exp();
        pair_t p;
        p.a = to_exp(ma);
        p.b = to_exp(mb);
        sb.push_back(p);
    endtask

    task automatic compare_front();
        pair_t p;
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'(sb.size()), 1);
        end else begin
            p = sb.pop_front();
            check("a.gnt",     gnt_a, p.a.gnt);
            check("a.gnt_id",  gid_a, p.a.gid);
            check("a.bus_out", bus_a, p.a.bus);
            check("a.valid",   bv_a,  p.a.bv);
            check("a.timeout", to_a,  p.a.to);
            check("b.gnt",     gnt_b, p.b.gnt);
            check("b.gnt_id",  gid_b, p.b.gid);
            check("b.bus_out", bus_b, p.b.bus);
            check("b.valid",   bv_b,  p.b.bv);
            check("b.timeout", to_b,  p.b.to);
        end
    endtask

    // One clock edge: new random data, model step, edge, compare, statistics.
    task automatic step();
        data_in = $urandom;
        if (r) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_next(ma, req, data_in, 15);
            mb = mdl_next(mb, req, data_in, 0);
        end
        push_exp();
        @(posedge clk);
        #1;
        compare_front();
        if (to_a) to_cnt_a++;
        if (to_b) to_cnt_b++;
        if (gnt_b == 4'b0100) hold_b++;
        run_a = bv_a ? run_a + 1 : 0;
        if (run_a > max_run_a) max_run_a = run_a;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset: outputs clear without a clock edge.
    task automatic apply_reset();
        r = 1'b1;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        push_exp();
        compare_front();
        step();
        r = 1'b0;
    endtask

    task automatic clear_stats();
        to_cnt_a = 0; to_cnt_b = 0; run_a = 0; max_run_a = 0; hold_b = 0;
    endtask

    initial begin
        r       = 1'b0;
        req     = 4'b0000;
        data_in = '0;
        ma      = mdl_reset();
        mb      = mdl_reset();
        clear_stats();
        #2;

        // 1: every requester active through reset; requester 0 wins first
        req = 4'b1111;
        apply_reset();
        step();
        check("t1.gnt", gnt_a, 4'b0001);
        check("t1.gnt_id", gid_a, 0);
        step();
        check("t1.valid", bv_a, 1);
        check("t1.bus", bus_a, data_in[7:0]);
        steps(20);

        // 2: requesters 0 and 2 alternate with a forced release every 15 beats
        req = 4'b0101;
        apply_reset();
        clear_stats();
        steps(51);
        check("t2.timeouts_a", to_cnt_a, 3);
        check("t2.max_run_a", max_run_a, 15);
        check("t2.timeouts_b", to_cnt_b, 0);

        // 3: short lone request on requester 1
        req = 4'b0000;
        apply_reset();
        steps(2);
        req = 4'b0010;
        steps(3);
        req = 4'b0000;
        steps(4);

        // 4: requester 3 holds; the others queue up and then win in wrap order
        apply_reset();
        req = 4'b1000;
        steps(3);
        req = 4'b1111;
        steps(5);
        check("t4.hold", gnt_a, 4'b1000);
        req = 4'b0111;
        steps(2);
        check("t4.wrap", gnt_a, 4'b0001);
        steps(50);

        // 5: asynchronous reset in the middle of a grant
        apply_reset();
        req = 4'b0100;
        steps(4);
        #2;
        r = 1'b1;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        push_exp();
        compare_front();
        step();
        r   = 1'b0;
        req = 4'b0101;
        step();
        check("t5.first", gnt_a, 4'b0001);
        steps(3);

        // 6: unlimited hold keeps requester 2 granted
        apply_reset();
        req = 4'b0100;
        steps(2);
        clear_stats();
        req = 4'b0101;
        steps(100);
        check("t6.hold_b", hold_b, 100);
        check("t6.timeouts_b", to_cnt_b, 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
